// File: rtl/cache_tag_directory_pkg.sv
// Shared types and geometry helpers for the cache tag directory.
// Geometry functions are pure elaboration-time constants.
// No flow control lives here.
package cache_pkg;

    typedef enum logic [1:0] {
        LOOKUP     = 2'b00,
        PROBE      = 2'b01,
        INVALIDATE = 2'b10,
        FLUSH      = 2'b11
    } op_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int calc_off_w(int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int calc_sets(int cache_bytes, int line_bytes, int ways);
        return cache_bytes / (line_bytes * ways);
    endfunction

    function automatic int calc_idx_w(int cache_bytes, int line_bytes, int ways);
        return $clog2(calc_sets(cache_bytes, line_bytes, ways));
    endfunction

    function automatic int calc_tag_w(int addr_w, int cache_bytes, int line_bytes, int ways);
        return addr_w - calc_idx_w(cache_bytes, line_bytes, ways) - calc_off_w(line_bytes);
    endfunction

endpackage

// File: rtl/cache_tag_directory_if.sv
// Request/response bundle between requester and tag directory.
// Response arrives one cycle after an accepted request.
// Requester holds a request until req_ready; responses cannot be stalled.
// CACHE_TAG_DIRECTORY_STATS_EN adds the hit/miss counter outputs.
interface cache_tag_directory_if #(
    parameter int ADDR_W      = 64,
    parameter int LINE_BYTES  = 64,
    parameter int CACHE_BYTES = 16384,
    parameter int WAYS        = 8
);
    import cache_pkg::*;

    localparam int OFF_W = calc_off_w(LINE_BYTES);
    localparam int IDX_W = calc_idx_w(CACHE_BYTES, LINE_BYTES, WAYS);
    localparam int TAG_W = calc_tag_w(ADDR_W, CACHE_BYTES, LINE_BYTES, WAYS);
    localparam int WAY_W = $clog2(WAYS);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [WAY_W-1:0]  rsp_way;
    logic [TAG_W-1:0]  rsp_tag;
    logic [IDX_W-1:0]  rsp_index;
    logic [OFF_W-1:0]  rsp_offset;
    logic              rsp_evict_valid;
    logic [TAG_W-1:0]  rsp_evict_tag;
`ifdef CACHE_TAG_DIRECTORY_STATS_EN
    logic [31:0]       stat_hits;
    logic [31:0]       stat_misses;

    modport master (
        output req_valid, req_op, req_addr,
        input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_tag, rsp_index,
               rsp_offset, rsp_evict_valid, rsp_evict_tag, stat_hits, stat_misses
    );
    modport slave (
        input  req_valid, req_op, req_addr,
        output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_tag, rsp_index,
               rsp_offset, rsp_evict_valid, rsp_evict_tag, stat_hits, stat_misses
    );
`else
    modport master (
        output req_valid, req_op, req_addr,
        input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_tag, rsp_index,
               rsp_offset, rsp_evict_valid, rsp_evict_tag
    );
    modport slave (
        input  req_valid, req_op, req_addr,
        output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_tag, rsp_index,
               rsp_offset, rsp_evict_valid, rsp_evict_tag
    );
`endif
endinterface

// File: rtl/cache_tag_directory_lru_set.sv
// True-LRU victim choice and age update for one set.
// Purely combinational, zero latency.
// No flow control; the caller decides when next ages are committed.
module cache_lru_set #(
    parameter int WAYS  = 8,
    parameter int WAY_W = 3
) (
    input  logic [WAYS-1:0]            valid,
    input  logic [WAYS-1:0][WAY_W-1:0] age,
    input  logic [WAY_W-1:0]           touch_way,
    output logic [WAY_W-1:0]           victim_way,
    output logic [WAYS-1:0][WAY_W-1:0] age_next
);

    logic [WAY_W-1:0] touch_age;

    assign touch_age = age[touch_way];

    // Lowest invalid way wins; with a full set the oldest way (age WAYS-1) goes.
    always_comb begin
        victim_way = '0;
        if (&valid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
            end
        end else begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!valid[w]) victim_way = WAY_W'(w);
            end
        end
    end

    // Touched way becomes youngest; everything younger than it ages by one.
    always_comb begin
        age_next = age;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way) begin
                age_next[w] = '0;
            end else if (age[w] < touch_age) begin
                age_next[w] = age[w] + WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/cache_tag_directory.sv
// Set-associative tag directory: lookup/allocate, probe, invalidate, flush with true LRU.
// Registered response one cycle after accept; FLUSH answers after a SETS-cycle sweep.
// req_ready low while sweeping (reset/FLUSH); responses cannot be stalled.
// CACHE_TAG_DIRECTORY_STATS_EN adds saturating LOOKUP hit/miss counters.
module cache_tag_directory
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int LINE_BYTES  = 64,
    parameter int CACHE_BYTES = 16384,
    parameter int WAYS        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_tag_directory_if.slave  bus
);

    localparam int OFF_W = calc_off_w(LINE_BYTES);
    localparam int SETS  = calc_sets(CACHE_BYTES, LINE_BYTES, WAYS);
    localparam int IDX_W = calc_idx_w(CACHE_BYTES, LINE_BYTES, WAYS);
    localparam int TAG_W = calc_tag_w(ADDR_W, CACHE_BYTES, LINE_BYTES, WAYS);
    localparam int WAY_W = $clog2(WAYS);

    state_e state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic ready, accept, sweep_last;
    op_e  op;

    logic [SETS-1:0][WAYS-1:0]        valid_q;
    logic [WAYS-1:0][TAG_W-1:0]       tag_q [SETS];
    logic [WAYS-1:0][WAY_W-1:0]       age_q [SETS];

    logic [TAG_W-1:0]                 req_tag;
    logic [IDX_W-1:0]                 req_idx;
    logic [OFF_W-1:0]                 req_off;
    logic [WAYS-1:0]                  set_valid;
    logic [WAYS-1:0][TAG_W-1:0]       set_tag;
    logic [WAYS-1:0][WAY_W-1:0]       set_age;
    logic [WAYS-1:0]                  match;
    logic                             hit;
    logic [WAY_W-1:0]                 hit_way, victim_way, touch_way;
    logic [WAYS-1:0][WAY_W-1:0]       age_next;

    logic                             rsp_valid_q, rsp_hit_q, rsp_evict_valid_q;
    logic [WAY_W-1:0]                 rsp_way_q;
    logic [TAG_W-1:0]                 rsp_tag_q, rsp_evict_tag_q;
    logic [IDX_W-1:0]                 rsp_index_q;
    logic [OFF_W-1:0]                 rsp_offset_q;
    logic                             pend_flush_q;
    logic [TAG_W-1:0]                 pend_tag_q;
    logic [IDX_W-1:0]                 pend_index_q;
    logic [OFF_W-1:0]                 pend_offset_q;

    assign op        = op_e'(bus.req_op);
    assign req_off   = bus.req_addr[OFF_W-1:0];
    assign req_idx   = bus.req_addr[OFF_W +: IDX_W];
    assign req_tag   = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign set_valid = valid_q[req_idx];
    assign set_tag   = tag_q[req_idx];
    assign set_age   = age_q[req_idx];

    // Tag compare across the indexed set; lowest matching way reported.
    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = set_valid[w] && (set_tag[w] == req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit       = |match;
    assign touch_way = hit ? hit_way : victim_way;

    cache_lru_set #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
        .valid      (set_valid),
        .age        (set_age),
        .touch_way  (touch_way),
        .victim_way (victim_way),
        .age_next   (age_next)
    );

    // State register for the sweep/run controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Next state: sweep every set once, run until a FLUSH restarts the sweep.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ready   = 1'b0;
        case (state_q)
            INIT: begin
                if (sweep_q == IDX_W'(SETS - 1)) begin
                    state_d = RUN;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + IDX_W'(1);
                end
            end
            RUN: begin
                ready = 1'b1;
                if (bus.req_valid && op == FLUSH) begin
                    state_d = INIT;
                    sweep_d = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign accept     = bus.req_valid && ready;
    assign sweep_last = (state_q == INIT) && (sweep_q == IDX_W'(SETS - 1));

    // Directory arrays: sweep clears one set per cycle, otherwise apply the accepted op.
    always_ff @(posedge clk) begin
        if (!rst && state_q == INIT) begin
            valid_q[sweep_q] <= '0;
            for (int w = 0; w < WAYS; w++) begin
                age_q[sweep_q][w] <= WAY_W'(w);
            end
        end else if (!rst && accept) begin
            case (op)
                LOOKUP: begin
                    age_q[req_idx] <= age_next;
                    if (!hit) begin
                        tag_q[req_idx][victim_way]   <= req_tag;
                        valid_q[req_idx][victim_way] <= 1'b1;
                    end
                end
                INVALIDATE: begin
                    if (hit) valid_q[req_idx][hit_way] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Response register; a FLUSH is parked until its sweep completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q       <= 1'b0;
            rsp_hit_q         <= 1'b0;
            rsp_way_q         <= '0;
            rsp_tag_q         <= '0;
            rsp_index_q       <= '0;
            rsp_offset_q      <= '0;
            rsp_evict_valid_q <= 1'b0;
            rsp_evict_tag_q   <= '0;
            pend_flush_q      <= 1'b0;
            pend_tag_q        <= '0;
            pend_index_q      <= '0;
            pend_offset_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept && op == FLUSH) begin
                pend_flush_q  <= 1'b1;
                pend_tag_q    <= req_tag;
                pend_index_q  <= req_idx;
                pend_offset_q <= req_off;
            end else if (accept) begin
                rsp_valid_q       <= 1'b1;
                rsp_hit_q         <= hit;
                rsp_tag_q         <= req_tag;
                rsp_index_q       <= req_idx;
                rsp_offset_q      <= req_off;
                rsp_evict_valid_q <= 1'b0;
                rsp_evict_tag_q   <= '0;
                if (op == LOOKUP) begin
                    rsp_way_q <= hit ? hit_way : victim_way;
                    if (!hit && set_valid[victim_way]) begin
                        rsp_evict_valid_q <= 1'b1;
                        rsp_evict_tag_q   <= set_tag[victim_way];
                    end
                end else begin
                    rsp_way_q <= hit ? hit_way : '0;
                end
            end else if (sweep_last && pend_flush_q) begin
                pend_flush_q      <= 1'b0;
                rsp_valid_q       <= 1'b1;
                rsp_hit_q         <= 1'b0;
                rsp_way_q         <= '0;
                rsp_tag_q         <= pend_tag_q;
                rsp_index_q       <= pend_index_q;
                rsp_offset_q      <= pend_offset_q;
                rsp_evict_valid_q <= 1'b0;
                rsp_evict_tag_q   <= '0;
            end
        end
    end

    assign bus.req_ready       = ready;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_hit         = rsp_hit_q;
    assign bus.rsp_way         = rsp_way_q;
    assign bus.rsp_tag         = rsp_tag_q;
    assign bus.rsp_index       = rsp_index_q;
    assign bus.rsp_offset      = rsp_offset_q;
    assign bus.rsp_evict_valid = rsp_evict_valid_q;
    assign bus.rsp_evict_tag   = rsp_evict_tag_q;

`ifdef CACHE_TAG_DIRECTORY_STATS_EN
    logic [31:0] stat_hits_q, stat_misses_q;

    // Saturating LOOKUP hit/miss counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else if (accept && op == LOOKUP) begin
            if (hit) begin
                if (stat_hits_q != 32'hFFFF_FFFF) stat_hits_q <= stat_hits_q + 32'd1;
            end else begin
                if (stat_misses_q != 32'hFFFF_FFFF) stat_misses_q <= stat_misses_q + 32'd1;
            end
        end
    end

    assign bus.stat_hits   = stat_hits_q;
    assign bus.stat_misses = stat_misses_q;
`endif

    // A legal directory never holds the same tag in two valid ways of a set.
    a_single_match: assert property (@(posedge clk) disable iff (rst)
        (state_q == RUN && bus.req_valid) |-> $onehot0(match));

endmodule

// File: tb/tb_cache_tag_directory.sv
module tb_cache_tag_directory;
    import cache_pkg::*;

    typedef struct packed {
        logic        hit;
        logic [2:0]  way;
        logic [52:0] tag;
        logic [4:0]  idx;
        logic [5:0]  off;
        logic        ev;
        logic [52:0] evtag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cache_tag_directory_if #(.ADDR_W(64), .LINE_BYTES(64), .CACHE_BYTES(16384), .WAYS(8)) bus ();

    cache_tag_directory #(.ADDR_W(64), .LINE_BYTES(64), .CACHE_BYTES(16384), .WAYS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Drive one request, hold it until accepted, queue the expected response.
    task automatic send(input op_e op, input logic [63:0] addr, input logic hit,
                        input logic [2:0] way, input logic ev, input logic [52:0] evtag,
                        input bit expect_rsp);
        int n;
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("req_accept_timeout", {63'd0, bus.req_ready}, 64'd1);
        end else if (expect_rsp) begin
            e = '{hit: hit, way: way, tag: addr[63:11], idx: addr[10:6], off: addr[5:0],
                  ev: ev, evtag: evtag};
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Called on a negedge; counts cycles with req_ready low, bounded.
    task automatic count_ready_low(input string name, input int expv);
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(name, 64'(n), 64'(expv));
    endtask

    // Scoreboard monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t act, e;
        if (!rst && bus.rsp_valid) begin
            act = '{hit: bus.rsp_hit, way: bus.rsp_way, tag: bus.rsp_tag, idx: bus.rsp_index,
                    off: bus.rsp_offset, ev: bus.rsp_evict_valid, evtag: bus.rsp_evict_tag};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 hit=%0d way=%0d tag=%0h, required no response",
                         act.hit, act.way, act.tag);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL rsp_fields: got hit=%0d way=%0d tag=%0h idx=%0d off=%0d ev=%0d evtag=%0h, required hit=%0d way=%0d tag=%0h idx=%0d off=%0d ev=%0d evtag=%0h",
                             act.hit, act.way, act.tag, act.idx, act.off, act.ev, act.evtag,
                             e.hit, e.way, e.tag, e.idx, e.off, e.ev, e.evtag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready",       {63'd0, bus.req_ready},       64'd0);
        check("rst_rsp_valid",   {63'd0, bus.rsp_valid},       64'd0);
        check("rst_rsp_hit",     {63'd0, bus.rsp_hit},         64'd0);
        check("rst_rsp_way",     64'(bus.rsp_way),             64'd0);
        check("rst_rsp_tag",     64'(bus.rsp_tag),             64'd0);
        check("rst_rsp_index",   64'(bus.rsp_index),           64'd0);
        check("rst_rsp_offset",  64'(bus.rsp_offset),          64'd0);
        check("rst_evict_valid", {63'd0, bus.rsp_evict_valid}, 64'd0);
        check("rst_evict_tag",   64'(bus.rsp_evict_tag),       64'd0);
        rst = 1'b0;
        count_ready_low("init_ready_low", 32);

        // First allocate then hit in set 1.
        send(LOOKUP, 64'h1040, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        send(LOOKUP, 64'h1040, 1'b1, 3'd0, 1'b0, 53'd0, 1'b1);

        // Fill set 1 (tag 2+k in way k), then LRU replacement.
        for (int k = 0; k < 8; k++)
            send(LOOKUP, 64'h1040 + 64'(k) * 64'h800, (k == 0), 3'(k), 1'b0, 53'd0, 1'b1);
        send(LOOKUP, 64'h5040, 1'b0, 3'd0, 1'b1, 53'd2, 1'b1);
        send(LOOKUP, 64'h1840, 1'b1, 3'd1, 1'b0, 53'd0, 1'b1);
        send(LOOKUP, 64'h5840, 1'b0, 3'd2, 1'b1, 53'd4, 1'b1);

        // Back-to-back same-address lookups: miss then hit.
        send(LOOKUP, 64'h2080, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        send(LOOKUP, 64'h2080, 1'b1, 3'd0, 1'b0, 53'd0, 1'b1);

        // Probe/invalidate in set 3.
        send(PROBE, 64'h90C0, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        send(PROBE, 64'h90C0, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        for (int k = 0; k < 8; k++)
            send(LOOKUP, 64'h10C0 + 64'(k) * 64'h800, 1'b0, 3'(k), 1'b0, 53'd0, 1'b1);
        send(PROBE,      64'h18FF, 1'b1, 3'd1, 1'b0, 53'd0, 1'b1);
        send(INVALIDATE, 64'h10C0, 1'b1, 3'd0, 1'b0, 53'd0, 1'b1);
        send(INVALIDATE, 64'h90C0, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        send(PROBE,      64'h10C0, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        send(LOOKUP,     64'h10C0, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        send(PROBE, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);

        // FLUSH in the middle of traffic.
        send(LOOKUP, 64'h3000, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        send(FLUSH,  64'h1840, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        count_ready_low("flush_ready_low", 32);
        check("flush_rsp_timing", {63'd0, bus.rsp_valid}, 64'd1);
        send(LOOKUP, 64'h1840, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        send(LOOKUP, 64'h3000, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        idle();

        // Reset partway through a FLUSH sweep: sweep restarts, flush response dropped.
        send(FLUSH, 64'h1840, 1'b0, 3'd0, 1'b0, 53'd0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready",     {63'd0, bus.req_ready}, 64'd0);
        check("midrst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        rst = 1'b0;
        count_ready_low("midrst_ready_low", 32);
        repeat (4) @(negedge clk);

`ifdef CACHE_TAG_DIRECTORY_STATS_EN
        // Counters: 5 misses, 3 hits; FLUSH keeps them, reset clears them.
        for (int k = 0; k < 5; k++)
            send(LOOKUP, 64'(k) * 64'h800, 1'b0, 3'(k), 1'b0, 53'd0, 1'b1);
        for (int k = 0; k < 3; k++)
            send(LOOKUP, 64'(k) * 64'h800, 1'b1, 3'(k), 1'b0, 53'd0, 1'b1);
        send(PROBE, 64'h0, 1'b1, 3'd0, 1'b0, 53'd0, 1'b1);
        idle();
        check("stat_hits",   64'(bus.stat_hits),   64'd3);
        check("stat_misses", 64'(bus.stat_misses), 64'd5);
        send(FLUSH, 64'h0, 1'b0, 3'd0, 1'b0, 53'd0, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        count_ready_low("stats_flush_ready_low", 32);
        check("stat_hits_after_flush",   64'(bus.stat_hits),   64'd3);
        check("stat_misses_after_flush", 64'(bus.stat_misses), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("stat_hits_after_rst",   64'(bus.stat_hits),   64'd0);
        check("stat_misses_after_rst", 64'(bus.stat_misses), 64'd0);
        count_ready_low("stats_rst_ready_low", 32);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
